// File: rtl/cmip_intc_msi.sv
// rtl/cmip_intc_msi.sv - per-source level/edge interrupt controller with MSI req/ack and legacy irq
//
// Purpose:
//   Collects SRC_NUM interrupt sources. Each source has its own polarity and
//   trigger mode (level or rising edge of the active signal). Pending events
//   are latched into sticky write-1-to-clear flags. Every pending and enabled
//   flag produces exactly one MSI request through a req/ack handshake. The
//   lowest index is served first. An optional holdoff inserts idle cycles
//   after each acknowledge. A legacy level interrupt is also driven.
//
// Configuration:
//   CMIP_INTC_HOLDOFF_EN - when defined, the HOLD state and the holdoff
//   counter are built. When undefined, REQ returns straight to IDLE after the
//   ack, and i_holdoff is ignored.
//
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_sig        raw interrupt sources
//   i_polar      per-source polarity (1 = active high)
//   i_edge_mode  per-source trigger mode (1 = edge, 0 = level)
//   i_enable     per-source mask for MSI and o_irq
//   i_clr        write-1-to-clear pulses for o_irq_flag
//   i_irq_polar  polarity of o_irq (1 = active high)
//   i_holdoff    idle cycles enforced after each MSI ack
//   o_irq_flag   sticky pending flags
//   o_irq        legacy level interrupt
//   o_msi_req    MSI request
//   o_msi_vec    MSI vector, stable while o_msi_req is high
//   i_msi_ack    one-cycle MSI acknowledge

module cmip_intc_msi #(
    parameter int SRC_NUM   = 32,
    parameter int VEC_WDTH  = 5,
    parameter int HOLD_WDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [SRC_NUM-1:0]   i_sig,
    input  logic [SRC_NUM-1:0]   i_polar,
    input  logic [SRC_NUM-1:0]   i_edge_mode,
    input  logic [SRC_NUM-1:0]   i_enable,
    input  logic [SRC_NUM-1:0]   i_clr,
    input  logic                 i_irq_polar,
    input  logic [HOLD_WDTH-1:0] i_holdoff,
    output logic [SRC_NUM-1:0]   o_irq_flag,
    output logic                 o_irq,
    output logic                 o_msi_req,
    output logic [VEC_WDTH-1:0]  o_msi_vec,
    input  logic                 i_msi_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SRC_NUM-1:0]   act;
    logic [SRC_NUM-1:0]   act_d1_q, act_d1_d;
    logic [SRC_NUM-1:0]   evt;
    logic [SRC_NUM-1:0]   flag_q, flag_d;
    logic [SRC_NUM-1:0]   sent_q, sent_d;
    logic [SRC_NUM-1:0]   cand;
    logic [SRC_NUM-1:0]   flag_en;
    logic [VEC_WDTH-1:0]  low_vec;
    logic                 msi_req_q, msi_req_d;
    logic [VEC_WDTH-1:0]  msi_vec_q, msi_vec_d;

`ifdef CMIP_INTC_HOLDOFF_EN
    logic [HOLD_WDTH-1:0] hold_cnt_q, hold_cnt_d;
`else
    logic                 unused_holdoff;
    assign unused_holdoff = ^i_holdoff;
`endif

    // Source decoding: XNOR with the polarity yields an active-high view.
    assign act = i_sig ~^ i_polar;

    // Edge mode fires on the rising edge of the active view only.
    assign evt = (i_edge_mode & act & ~act_d1_q) | (~i_edge_mode & act);

    // Flag update: a new event beats a simultaneous clear on the same bit.
    always_comb begin
        act_d1_d = act;
        flag_d   = (flag_q & ~i_clr) | evt;
    end

    assign cand    = flag_q & i_enable & ~sent_q;
    assign flag_en = flag_q & i_enable;

    // Legacy interrupt, combinational from the registered flags.
    assign o_irq = i_irq_polar ? (|flag_en) : ~(|flag_en);

    // Lowest-indexed candidate wins; scanning downward leaves the lowest last.
    always_comb begin
        low_vec = '0;
        for (int i = SRC_NUM - 1; i >= 0; i--) begin
            if (cand[i]) begin
                low_vec = VEC_WDTH'(i);
            end
        end
    end

    // MSI sequencing and the sent mask.
    always_comb begin
        state_d   = state_q;
        msi_req_d = msi_req_q;
        msi_vec_d = msi_vec_q;
        // A sent mark drops with its flag. A clear also re-arms the source so
        // a level source still active after a clear produces a fresh MSI.
        sent_d    = sent_q & flag_d & ~i_clr;
`ifdef CMIP_INTC_HOLDOFF_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|cand) begin
                    msi_req_d = 1'b1;
                    msi_vec_d = low_vec;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                // Once issued, a request is held until acked regardless of
                // what happens to its flag or enable meanwhile.
                if (i_msi_ack) begin
                    msi_req_d         = 1'b0;
                    sent_d[msi_vec_q] = flag_d[msi_vec_q];
`ifdef CMIP_INTC_HOLDOFF_EN
                    if (i_holdoff != '0) begin
                        hold_cnt_d = i_holdoff;
                        state_d    = ST_HOLD;
                    end else begin
                        state_d    = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef CMIP_INTC_HOLDOFF_EN
            ST_HOLD: begin
                // Counter was loaded with the holdoff on entry; leaving when it
                // reads 1 gives exactly i_holdoff cycles in HOLD.
                if (hold_cnt_q <= HOLD_WDTH'(1)) begin
                    hold_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_WDTH'(1);
                end
            end
`endif
            default: begin
                state_d   = ST_IDLE;
                msi_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            act_d1_q   <= '0;
            flag_q     <= '0;
            sent_q     <= '0;
            msi_req_q  <= 1'b0;
            msi_vec_q  <= '0;
`ifdef CMIP_INTC_HOLDOFF_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            act_d1_q   <= act_d1_d;
            flag_q     <= flag_d;
            sent_q     <= sent_d;
            msi_req_q  <= msi_req_d;
            msi_vec_q  <= msi_vec_d;
`ifdef CMIP_INTC_HOLDOFF_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    assign o_irq_flag = flag_q;
    assign o_msi_req  = msi_req_q;
    assign o_msi_vec  = msi_vec_q;

endmodule

// File: tb/tb_cmip_intc_msi.sv
// tb/tb_cmip_intc_msi.sv - directed self-checking bench for cmip_intc_msi

module tb_cmip_intc_msi;

    localparam int N  = 32;
    localparam int VW = 5;
    localparam int HW = 16;
`ifdef CMIP_INTC_HOLDOFF_EN
    localparam int EXP_GAP = 11;
`else
    localparam int EXP_GAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  i_sig, i_polar, i_edge_mode, i_enable, i_clr;
    logic          i_irq_polar;
    logic [HW-1:0] i_holdoff;
    logic [N-1:0]  o_irq_flag;
    logic          o_irq;
    logic          o_msi_req;
    logic [VW-1:0] o_msi_vec;
    logic          i_msi_ack;

    int checks   = 0;
    int failures = 0;
    int k;
    int seen;

    always #5 clk = ~clk;

    cmip_intc_msi #(.SRC_NUM(N), .VEC_WDTH(VW), .HOLD_WDTH(HW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sig       (i_sig),
        .i_polar     (i_polar),
        .i_edge_mode (i_edge_mode),
        .i_enable    (i_enable),
        .i_clr       (i_clr),
        .i_irq_polar (i_irq_polar),
        .i_holdoff   (i_holdoff),
        .o_irq_flag  (o_irq_flag),
        .o_irq       (o_irq),
        .o_msi_req   (o_msi_req),
        .o_msi_vec   (o_msi_vec),
        .i_msi_ack   (i_msi_ack)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_once();
        i_msi_ack = 1'b1;
        step();
        i_msi_ack = 1'b0;
    endtask

    task automatic clear_bits(input logic [N-1:0] bits);
        i_clr = bits;
        step();
        i_clr = '0;
    endtask

    task automatic wait_req(output int cyc);
        cyc = 0;
        while (!o_msi_req && cyc < 40) begin
            step();
            cyc++;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        i_sig       = '0;
        i_polar     = '1;
        i_edge_mode = '0;
        i_enable    = '1;
        i_clr       = '0;
        i_irq_polar = 1'b1;
        i_holdoff   = '0;
        i_msi_ack   = 1'b0;

        // Reset state
        step();
        step();
        check_eq("rst_flag", o_irq_flag, 0);
        check_eq("rst_req", o_msi_req, 0);
        check_eq("rst_vec", o_msi_vec, 0);
        check_eq("rst_irq_hi", o_irq, 0);
        i_irq_polar = 1'b0;
        #1;
        check_eq("rst_irq_lo", o_irq, 1);
        i_irq_polar = 1'b1;
        rst_n = 1'b1;
        step();

        // Level source 3
        i_sig[3] = 1'b1;
        step();
        check_eq("t1_flag", o_irq_flag[3], 1);
        check_eq("t1_req_early", o_msi_req, 0);
        check_eq("t1_irq", o_irq, 1);
        step();
        check_eq("t1_req", o_msi_req, 1);
        check_eq("t1_vec", o_msi_vec, 3);
        ack_once();
        check_eq("t1_req_drop", o_msi_req, 0);
        seen = 0;
        repeat (5) begin
            step();
            if (o_msi_req) seen++;
        end
        check_eq("t1_single_msi", seen, 0);
        clear_bits(32'h8);
        check_eq("t1_flag_reset", o_irq_flag[3], 1);
        step();
        check_eq("t1_req2", o_msi_req, 1);
        check_eq("t1_vec2", o_msi_vec, 3);
        ack_once();
        check_eq("t1_req2_drop", o_msi_req, 0);
        i_sig[3] = 1'b0;
        clear_bits(32'h8);
        check_eq("t1_cleared", o_irq_flag, 0);

        // Edge source 7, active low
        i_sig[7]       = 1'b1;
        i_polar[7]     = 1'b0;
        i_edge_mode[7] = 1'b1;
        step();
        step();
        check_eq("t2_idle_flag", o_irq_flag, 0);
        i_sig[7] = 1'b0;
        step();
        i_sig[7] = 1'b1;
        check_eq("t2_flag", o_irq_flag, 32'h80);
        step();
        check_eq("t2_req", o_msi_req, 1);
        check_eq("t2_vec", o_msi_vec, 7);
        step();
        step();
        check_eq("t2_req_hold", o_msi_req, 1);
        check_eq("t2_vec_hold", o_msi_vec, 7);
        ack_once();
        check_eq("t2_req_drop", o_msi_req, 0);
        repeat (3) step();
        check_eq("t2_sticky", o_irq_flag[7], 1);
        check_eq("t2_no_second", o_msi_req, 0);
        clear_bits(32'h80);
        check_eq("t2_cleared", o_irq_flag, 0);
        i_polar[7]     = 1'b1;
        i_edge_mode[7] = 1'b0;
        i_sig[7]       = 1'b0;
        step();

        // Simultaneous sources 2 and 9 with holdoff
        i_holdoff = 16'd10;
        i_sig[2]  = 1'b1;
        i_sig[9]  = 1'b1;
        step();
        check_eq("t3_flags", o_irq_flag, 32'h204);
        step();
        check_eq("t3_req1", o_msi_req, 1);
        check_eq("t3_vec1", o_msi_vec, 2);
        ack_once();
        check_eq("t3_req1_drop", o_msi_req, 0);
        i_holdoff = '0;
        wait_req(k);
        check_eq("t3_gap", k, EXP_GAP);
        check_eq("t3_vec2", o_msi_vec, 9);
        ack_once();
        i_sig[2] = 1'b0;
        i_sig[9] = 1'b0;
        clear_bits(32'h204);
        repeat (3) step();
        check_eq("t3_done_flag", o_irq_flag, 0);
        check_eq("t3_done_req", o_msi_req, 0);

        // Clear/event collision on 4, plain clear on 5 (both masked)
        i_enable[4]    = 1'b0;
        i_enable[5]    = 1'b0;
        i_edge_mode[4] = 1'b1;
        step();
        i_sig[5] = 1'b1;
        step();
        i_sig[5] = 1'b0;
        i_sig[4] = 1'b1;
        step();
        i_sig[4] = 1'b0;
        step();
        check_eq("t4_pre", o_irq_flag, 32'h30);
        check_eq("t4_irq_masked", o_irq, 0);
        i_clr    = 32'h30;
        i_sig[4] = 1'b1;
        step();
        i_clr    = '0;
        i_sig[4] = 1'b0;
        check_eq("t4_collide", o_irq_flag, 32'h10);
        check_eq("t4_no_req", o_msi_req, 0);
        clear_bits(32'h10);
        check_eq("t4_cleared", o_irq_flag, 0);
        i_enable[4]    = 1'b1;
        i_enable[5]    = 1'b1;
        i_edge_mode[4] = 1'b0;
        step();

        // Mask and legacy polarity on source 1
        i_enable[1] = 1'b0;
        i_sig[1]    = 1'b1;
        step();
        i_sig[1] = 1'b0;
        step();
        step();
        check_eq("t5_flag", o_irq_flag, 32'h2);
        check_eq("t5_no_req", o_msi_req, 0);
        check_eq("t5_irq_hi_off", o_irq, 0);
        i_irq_polar = 1'b0;
        #1;
        check_eq("t5_irq_lo_off", o_irq, 1);
        i_enable[1] = 1'b1;
        #1;
        check_eq("t5_irq_lo_on", o_irq, 0);
        step();
        check_eq("t5_req", o_msi_req, 1);
        check_eq("t5_vec", o_msi_vec, 1);
        i_irq_polar = 1'b1;
        #1;
        check_eq("t5_irq_hi_on", o_irq, 1);
        ack_once();
        check_eq("t5_req_drop", o_msi_req, 0);
        clear_bits(32'h2);
        check_eq("t5_irq_idle", o_irq, 0);

        // Reset in the middle of a handshake
        i_sig[3] = 1'b1;
        step();
        step();
        check_eq("t6_req", o_msi_req, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_req", o_msi_req, 0);
        check_eq("t6_rst_flag", o_irq_flag, 0);
        check_eq("t6_rst_vec", o_msi_vec, 0);
        #2;
        rst_n = 1'b1;
        step();
        check_eq("t6_flag", o_irq_flag, 32'h8);
        check_eq("t6_req_early", o_msi_req, 0);
        step();
        check_eq("t6_req2", o_msi_req, 1);
        check_eq("t6_vec2", o_msi_vec, 3);
        ack_once();
        i_sig[3] = 1'b0;
        clear_bits(32'h8);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
